// File: rtl/c16_keyscan_pkg.sv
// +------------------------------------------------------------------+
// | c16_pkg: shared constants and scan FSM encoding for c16_keyscan  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package c16_pkg;

   localparam int KEY_COUNT   = 65;
   localparam int ROWS        = 8;
   localparam int COLS        = 8;
   localparam int RESTORE_IDX = 64;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRIVE  = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_UPDATE = 2'd3
   } keyscan_state_t;

endpackage

`default_nettype wire

// File: rtl/c16_keyscan_key_debounce.sv
// +------------------------------------------------------------------+
// | c16_key_debounce: frame-based debounce counter for a single key  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module c16_key_debounce
   import c16_pkg::*;
#(
   parameter int DEBOUNCE_SCANS = 4
)(
   input  logic clk,
   input  logic reset,
   input  logic update,
   input  logic raw,
   output logic key
);

   localparam logic [3:0] c_cnt_last = 4'(DEBOUNCE_SCANS - 1);

   logic [3:0] r_cnt;

   // The counter only advances on frame updates, so it counts disagreeing frames.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= 4'd0;
         key   <= 1'b1;
      end else if (update) begin
         if (raw == key) begin
            r_cnt <= 4'd0;
         end else if (r_cnt == c_cnt_last) begin
            key   <= raw;
            r_cnt <= 4'd0;
         end else begin
            r_cnt <= r_cnt + 4'd1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/c16_keyscan.sv
// +------------------------------------------------------------------+
// | c16_keyscan: C64/C16 keyboard matrix row scanner with debounce   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module c16_keyscan
   import c16_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 64,
   parameter int DEBOUNCE_SCANS = 4
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [7:0]           col_in,
   input  logic                 restore_n,
   output logic [7:0]           row_out,
   output logic [KEY_COUNT-1:0] keys,
   output logic                 scan_done
);

   localparam int c_cnt_w = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [c_cnt_w-1:0] c_settle_last = c_cnt_w'(SETTLE_CYCLES - 1);

   localparam logic [1:0] c_st_idle   = ST_IDLE;
   localparam logic [1:0] c_st_drive  = ST_DRIVE;
   localparam logic [1:0] c_st_sample = ST_SAMPLE;
   localparam logic [1:0] c_st_update = ST_UPDATE;

   logic [1:0]           r_state;
   logic [2:0]           r_row_idx;
   logic [c_cnt_w-1:0]   r_settle_cnt;
   logic                 r_scan_done;
   logic [COLS-1:0]      r_col_meta;
   logic [COLS-1:0]      r_col_sync;
   logic                 r_restore_meta;
   logic                 r_restore_sync;
   logic [KEY_COUNT-1:0] w_raw;
   logic                 w_update;
   logic                 w_sample;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_col_meta     <= '1;
         r_col_sync     <= '1;
         r_restore_meta <= 1'b1;
         r_restore_sync <= 1'b1;
      end else begin
         r_col_meta     <= col_in;
         r_col_sync     <= r_col_meta;
         r_restore_meta <= restore_n;
         r_restore_sync <= r_restore_meta;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= c_st_idle;
         r_row_idx    <= 3'd0;
         r_settle_cnt <= '0;
         r_scan_done  <= 1'b0;
      end else begin
         r_scan_done <= (r_state == c_st_update);
         case (r_state)
            c_st_idle: begin
               if (enable) begin
                  r_row_idx    <= 3'd0;
                  r_settle_cnt <= '0;
                  r_state      <= c_st_drive;
               end
            end
            c_st_drive: begin
               r_settle_cnt <= r_settle_cnt + 1'b1;
               if (r_settle_cnt == c_settle_last) begin
                  r_state <= c_st_sample;
               end
            end
            c_st_sample: begin
               r_settle_cnt <= '0;
               if (r_row_idx == 3'd7) begin
                  r_state <= c_st_update;
               end else begin
                  r_row_idx <= r_row_idx + 3'd1;
                  r_state   <= c_st_drive;
               end
            end
            c_st_update: begin
               r_row_idx    <= 3'd0;
               r_settle_cnt <= '0;
               // Enable is only consulted here, so a frame always runs to completion.
               r_state      <= enable ? c_st_drive : c_st_idle;
            end
            default: begin
               r_state <= c_st_idle;
            end
         endcase
      end
   end

   assign w_sample  = (r_state == c_st_sample);
   assign w_update  = (r_state == c_st_update);
   assign scan_done = r_scan_done;

   always_comb begin
      row_out = 8'hFF;
      if ((r_state == c_st_drive) || (r_state == c_st_sample)) begin
         row_out = ~(8'h01 << r_row_idx);
      end
   end

   // Each column keeps its own 8 row samples so the raw vector is laid out col*8+row.
   generate
      for (genvar c = 0; c < COLS; c++) begin : g_col
         logic [ROWS-1:0] r_bits;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_bits <= '1;
            end else if (w_sample) begin
               r_bits[r_row_idx] <= r_col_sync[c];
            end
         end

         assign w_raw[c*ROWS +: ROWS] = r_bits;
      end
   endgenerate

   // Restore is taken straight from the synchroniser during the update cycle itself.
   assign w_raw[RESTORE_IDX] = r_restore_sync;

   generate
      for (genvar k = 0; k < KEY_COUNT; k++) begin : g_key
         c16_key_debounce #(
            .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
         ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .update (w_update),
            .raw    (w_raw[k]),
            .key    (keys[k])
         );
      end
   endgenerate

endmodule

`default_nettype wire
